qupls_bitfield_pipe: RTL

//  Pipelined, width-parametrised bitfield unit for the integer ALU cluster. Performs clear/set/

---
 rtl/qupls_bitfield_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/qupls_bitfield_pipe.sv
// qupls_bitfield_pipe: two-stage pipelined bitfield unit for the integer ALU cluster.
// Ops on field [mb..me] (may wrap past the MSB): CLR, SET, COM, EXTU, EXTS, DEP and,
// when QUPLS_BITFIELD_FFO_EN is defined, FFO. Op 7 (and op 6 without the macro) yield 0.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop every in-flight op on the next edge
//   in_valid/in_ready    input handshake
//   in_op, in_mb, in_me  opcode, field begin bit, field end bit (inclusive)
//   in_a, in_t, in_tag   source operand, deposit target, tag carried with the op
//   out_valid/out_ready  output handshake
//   out_res, out_tag     result and its tag
//
// Configuration macro: QUPLS_BITFIELD_FFO_EN (adds the S2 priority encoder for op 6).
module qupls_bitfield_pipe #(
  parameter int unsigned WID   = 64,
  parameter int unsigned TAG_W = 8,
  localparam int unsigned PW   = $clog2(WID)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [PW-1:0]    in_mb,
  input  logic [PW-1:0]    in_me,
  input  logic [WID-1:0]   in_a,
  input  logic [WID-1:0]   in_t,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WID-1:0]   out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OpClr = 3'd0;
  localparam logic [2:0] OpSet = 3'd1;
  localparam logic [2:0] OpCom = 3'd2;
  localparam logic [2:0] OpExu = 3'd3;
  localparam logic [2:0] OpExs = 3'd4;
  localparam logic [2:0] OpDep = 3'd5;
`ifdef QUPLS_BITFIELD_FFO_EN
  localparam logic [2:0] OpFfo = 3'd6;
`endif

  // Handshake
  logic s1_v, s2_v;
  logic accept, s2_load;

  assign in_ready  = !rst && (!s1_v || !s2_v || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign s2_load   = s1_v && (!s2_v || out_ready) && !flush;
  assign out_valid = s2_v;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (accept)       s1_v <= 1'b1;
      else if (s2_load) s1_v <= 1'b0;
      if (s2_load)        s2_v <= 1'b1;
      else if (out_ready) s2_v <= 1'b0;
    end
  end

  // Stage 0 combinational: mask and rotated operands
  logic [WID-1:0]   mask_c, masked_c, ext_c, low_c, dep_c;
  logic [2*WID-1:0] rr_c, rl_c, lr_c;

  always_comb begin
    for (int n = 0; n < int'(WID); n++) begin
      mask_c[n] = (n >= int'(in_mb)) ^ (n <= int'(in_me)) ^ (in_me >= in_mb);
    end
    masked_c = in_a & mask_c;
    // Rotate by doubling the word so a zero shift needs no special case.
    rr_c  = {masked_c, masked_c} >> in_mb;
    ext_c = rr_c[WID-1:0];
    lr_c  = {mask_c, mask_c} >> in_mb;
    low_c = lr_c[WID-1:0];           // ones in bits 0..w-1
    rl_c  = {in_a, in_a} << in_mb;
    dep_c = rl_c[2*WID-1:WID];
  end

  // Stage 1 registers
  logic [2:0]       s1_op;
  logic [WID-1:0]   s1_mask, s1_a, s1_t, s1_ext, s1_low, s1_dep;
  logic             s1_sgn;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op   <= in_op;
      s1_mask <= mask_c;
      s1_a    <= in_a;
      s1_t    <= in_t;
      s1_ext  <= ext_c;
      s1_low  <= low_c;
      s1_dep  <= dep_c;
      s1_sgn  <= in_a[in_me];
      s1_tag  <= in_tag;
    end
  end

`ifdef QUPLS_BITFIELD_FFO_EN
  // Highest set bit of the field-aligned value is the field-relative position.
  logic [WID-1:0] ffo_c;
  always_comb begin
    ffo_c = '1;
    for (int i = 0; i < int'(WID); i++) begin
      if (s1_ext[i]) ffo_c = WID'(i);
    end
  end
`endif

  // Stage 2 combinational result
  logic [WID-1:0] res_c;
  always_comb begin
    res_c = '0;
    case (s1_op)
      OpClr:   res_c = s1_a & ~s1_mask;
      OpSet:   res_c = s1_a | s1_mask;
      OpCom:   res_c = s1_a ^ s1_mask;
      OpExu:   res_c = s1_ext;
      OpExs:   res_c = s1_ext | (~s1_low & {WID{s1_sgn}});
      OpDep:   res_c = (s1_dep & s1_mask) | (s1_t & ~s1_mask);
`ifdef QUPLS_BITFIELD_FFO_EN
      OpFfo:   res_c = ffo_c;
`endif
      default: res_c = '0;
    endcase
  end

  // Stage 2 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_res <= '0;
      out_tag <= '0;
    end else if (s2_load) begin
      out_res <= res_c;
      out_tag <= s1_tag;
    end
  end

endmodule
